// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RV32I MEM stage: loads/stores over a req/ack data port into the MEM/WB registers
package memory_stage_pkg;
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } control_type;
endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] alu_data,
    input  logic [31:0] memory_data,
    input  control_type control_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output control_type control_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        bus_error
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt;
    control_type   lat_ctrl;
    logic [31:0]   lat_alu;
    logic [1:0]    off;
    logic [1:0]    size;
    logic [3:0]    be_calc;
    logic [31:0]   wdata_calc;
    logic [31:0]   lane;
    logic [31:0]   load_ext;
    logic          mem_op, aligned, timeout;
    logic          pass, take_misalign, do_latch, finish_ack, finish_timeout;

    assign off     = alu_data[1:0];
    assign mem_op  = in_valid & (control_in.mem_read | control_in.mem_write);
    assign timeout = (wait_cnt == CW'(MAX_WAIT - 1));

    // Access size: 0 = byte, 1 = half, 2 = word; unlisted funct3 falls back to word.
    always_comb begin
        size = 2'd2;
        case (control_in.funct3)
            3'b000, 3'b100: size = 2'd0;
            3'b001, 3'b101: size = 2'd1;
            default:        size = 2'd2;
        endcase
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = memory_data;
        aligned    = (off == 2'b00);
        case (size)
            2'd0: begin
                be_calc    = 4'b0001 << off;
                wdata_calc = {4{memory_data[7:0]}};
                aligned    = 1'b1;
            end
            2'd1: begin
                be_calc    = 4'b0011 << off;
                wdata_calc = {2{memory_data[15:0]}};
                aligned    = ~off[0];
            end
            default: ;
        endcase
    end

    assign lane = dmem_rdata >> {lat_alu[1:0], 3'b000};

    always_comb begin
        case (lat_ctrl.funct3)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'd0, lane[7:0]};
            3'b101:  load_ext = {16'd0, lane[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        pass           = 1'b0;
        take_misalign  = 1'b0;
        do_latch       = 1'b0;
        finish_ack     = 1'b0;
        finish_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    pass = 1'b1;
                end else if (aligned) begin
                    stall    = 1'b1;
                    do_latch = 1'b1;
                    state_d  = REQ;
                end else begin
                    take_misalign = 1'b1;
                end
            end
            REQ: begin
                // An ack in the timeout cycle wins over the timeout.
                if (dmem_ack) begin
                    finish_ack = 1'b1;
                    state_d    = IDLE;
                end else if (timeout) begin
                    finish_timeout = 1'b1;
                    state_d        = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset_n) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wait_cnt     <= '0;
            lat_ctrl     <= '0;
            lat_alu      <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            out_valid    <= 1'b0;
            control_out  <= '0;
            alu_data_out <= '0;
            read_data    <= '0;
            misaligned   <= 1'b0;
            bus_error    <= 1'b0;
        end else begin
            state_q    <= state_d;
            misaligned <= take_misalign;
            bus_error  <= finish_timeout;
            out_valid  <= pass ? in_valid : finish_ack;

            if (state_q == REQ && state_d == REQ) begin
                wait_cnt <= wait_cnt + CW'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (do_latch) begin
                dmem_req   <= 1'b1;
                dmem_we    <= control_in.mem_write;
                dmem_addr  <= {alu_data[31:2], 2'b00};
                dmem_be    <= be_calc;
                dmem_wdata <= wdata_calc;
                lat_ctrl   <= control_in;
                lat_alu    <= alu_data;
            end else if (finish_ack || finish_timeout) begin
                dmem_req <= 1'b0;
            end

            if (pass) begin
                control_out  <= control_in;
                alu_data_out <= alu_data;
                read_data    <= '0;
            end else if (finish_ack) begin
                control_out  <= lat_ctrl;
                alu_data_out <= lat_alu;
                read_data    <= (lat_ctrl.mem_read && !lat_ctrl.mem_write) ? load_ext : 32'd0;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized transaction-level bench for memory_stage
module tb_memory_stage;
    import memory_stage_pkg::*;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] alu_data;
    logic [31:0] memory_data;
    control_type control_in;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    control_type control_out;
    logic [31:0] alu_data_out;
    logic [31:0] read_data;
    logic        misaligned;
    logic        bus_error;

    int n_cmp = 0;
    int n_bad = 0;

    memory_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .alu_data     (alu_data),
        .memory_data  (memory_data),
        .control_in   (control_in),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .out_valid    (out_valid),
        .control_out  (control_out),
        .alu_data_out (alu_data_out),
        .read_data    (read_data),
        .misaligned   (misaligned),
        .bus_error    (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic control_type mk(bit rw, bit mr, bit mw, logic [2:0] f3);
        control_type c;
        c.reg_write = rw;
        c.mem_read  = mr;
        c.mem_write = mw;
        c.funct3    = f3;
        return c;
    endfunction

    function automatic int access_bytes(logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_be(logic [31:0] a, int nb);
        if (nb == 4) return 4'hF;
        return 4'(((1 << nb) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] d, int nb);
        if (nb == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (nb == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        case (f3)
            3'd0:    return 32'($signed(v[7:0]));
            3'd1:    return 32'($signed(v[15:0]));
            3'd4:    return v & 32'h0000_00FF;
            3'd5:    return v & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    // Entered and left at posedge+1. ack_dly: REQ cycle index carrying ack, -1 for never.
    task automatic run_instr(input string tag, input control_type c, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd, input int ack_dly);
        bit   is_mem, aligned_op, acked, got_ack, last_stall;
        int   nb, req_seen, stalls;
        is_mem     = c.mem_read || c.mem_write;
        nb         = access_bytes(c.funct3);
        aligned_op = (a % nb) == 0;
        acked      = ack_dly >= 0 && ack_dly < MAX_WAIT;
        in_valid    = 1'b1;
        control_in  = c;
        alu_data    = a;
        memory_data = d;
        dmem_ack    = 1'b0;
        @(negedge clk);
        if (!is_mem || !aligned_op) begin
            check({tag, ":stall"}, 32'(stall), 32'd0);
            check({tag, ":no_req"}, 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check({tag, ":out_valid"}, 32'(out_valid), 32'(!is_mem));
            check({tag, ":misaligned"}, 32'(misaligned), 32'(is_mem));
            check({tag, ":req_after"}, 32'(dmem_req), 32'd0);
            if (!is_mem) begin
                check({tag, ":alu_out"}, alu_data_out, a);
                check({tag, ":rdata0"}, read_data, 32'd0);
                check({tag, ":ctrl_out"}, 32'(control_out), 32'(c));
            end
        end else begin
            check({tag, ":idle_stall"}, 32'(stall), 32'd1);
            check({tag, ":idle_req"}, 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
            check({tag, ":bubble"}, 32'(out_valid), 32'd0);
            req_seen = 0;
            stalls   = 1;
            got_ack  = 1'b0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                dmem_ack   = (ack_dly == req_seen);
                dmem_rdata = rd;
                @(negedge clk);
                if (!dmem_req) break;
                if (req_seen == 0) begin
                    check({tag, ":addr"}, dmem_addr, a & 32'hFFFF_FFFC);
                    check({tag, ":be"}, 32'(dmem_be), 32'(model_be(a, nb)));
                    check({tag, ":we"}, 32'(dmem_we), 32'(c.mem_write));
                    if (c.mem_write) check({tag, ":wdata"}, dmem_wdata, model_wdata(d, nb));
                end
                last_stall = stall;
                if (stall) stalls++;
                got_ack = dmem_ack;
                req_seen++;
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                if (!last_stall) in_valid = 1'b0;
                if (got_ack) break;
            end
            dmem_ack = 1'b0;
            in_valid = 1'b0;
            check({tag, ":req_cycles"}, 32'(req_seen), 32'(acked ? ack_dly + 1 : MAX_WAIT));
            check({tag, ":stall_cycles"}, 32'(stalls), 32'(1 + (acked ? ack_dly : MAX_WAIT - 1)));
            check({tag, ":out_valid"}, 32'(out_valid), 32'(acked));
            check({tag, ":bus_error"}, 32'(bus_error), 32'(!acked));
            check({tag, ":req_drop"}, 32'(dmem_req), 32'd0);
            if (acked) begin
                check({tag, ":read_data"}, read_data,
                      (c.mem_read && !c.mem_write) ? model_load(c.funct3, a, rd) : 32'd0);
                check({tag, ":alu_out"}, alu_data_out, a);
                check({tag, ":ctrl_out"}, 32'(control_out), 32'(c));
            end
        end
        @(posedge clk); #1;
        check({tag, ":single_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":pulses_low"}, 32'({misaligned, bus_error}), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        control_type c;
        logic [31:0] a;
        int          kind, nb, r, dly;

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        alu_data    = '0;
        memory_data = '0;
        control_in  = '0;
        dmem_ack    = 1'b0;
        dmem_rdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:out_valid", 32'(out_valid), 32'd0);
        check("rst:req", 32'(dmem_req), 32'd0);
        check("rst:ctrl", 32'(control_out), 32'd0);
        check("rst:outs", alu_data_out | read_data | dmem_addr | dmem_wdata, 32'd0);
        check("rst:flags", 32'({stall, dmem_we, dmem_be, misaligned, bus_error}), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Reset asserted while a load is waiting for ack
        in_valid   = 1'b1;
        control_in = mk(1, 1, 0, 3'd2);
        alu_data   = 32'h200;
        repeat (3) @(posedge clk);
        #1;
        check("rstreq:req_before", 32'(dmem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstreq:req", 32'(dmem_req), 32'd0);
        check("rstreq:stall", 32'(stall), 32'd0);
        check("rstreq:outs", 32'({out_valid, misaligned, bus_error}), 32'd0);
        check("rstreq:ctrl", 32'(control_out), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rstreq:idle_req", 32'(dmem_req), 32'd0);
        check("rstreq:idle_valid", 32'(out_valid), 32'd0);

        run_instr("sw",   mk(0, 0, 1, 3'd2), 32'h100, 32'hDEAD_BEEF, 32'h0, 2);
        run_instr("lb",   mk(1, 1, 0, 3'd0), 32'h103, 32'h0, 32'h8000_0000, 0);
        run_instr("lbu",  mk(1, 1, 0, 3'd4), 32'h103, 32'h0, 32'h8000_0000, 0);
        run_instr("sh",   mk(0, 0, 1, 3'd1), 32'h102, 32'h0000_1234, 32'h0, 1);
        run_instr("lh",   mk(1, 1, 0, 3'd1), 32'h102, 32'h0, 32'h8001_5A5A, 0);
        run_instr("lw_mis", mk(1, 1, 0, 3'd2), 32'h101, 32'h0, 32'h0, 0);
        run_instr("add",  mk(1, 0, 0, 3'd0), 32'h7, 32'h0, 32'h0, 0);
        run_instr("sh_mis", mk(0, 0, 1, 3'd1), 32'h203, 32'h55, 32'h0, 0);
        run_instr("lw_to", mk(1, 1, 0, 3'd2), 32'h40, 32'h0, 32'h1234_5678, -1);
        run_instr("lw_after", mk(1, 1, 0, 3'd2), 32'h44, 32'h0, 32'hCAFE_F00D, 1);
        run_instr("lw_edge", mk(1, 1, 0, 3'd2), 32'h48, 32'h0, 32'h0BAD_CAFE, MAX_WAIT - 1);
        run_instr("lx_unl", mk(1, 1, 0, 3'd7), 32'h4C, 32'h0, 32'h8765_4321, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) c = mk(1'($urandom), 0, 0, 3'($urandom));
            else if (kind == 1) c = mk(1, 1, 0, 3'($urandom));
            else c = mk(0, 0, 1, 3'($urandom_range(0, 2)));
            nb = access_bytes(c.funct3);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nb - 1);
            r   = $urandom_range(0, 9);
            dly = (r == 9) ? -1 : r;
            run_instr("rnd", c, a, $urandom, $urandom, dly);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
